// File: rtl/frame_reader_if.sv
// frame_reader port bundle: control, frame-buffer read bus and pixel stream.
// master = reader side, slave = frame buffer / consumer side.
interface frame_reader_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  start;
  logic                  pattern_sel;
  logic                  busy;
  logic                  done;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_rd_data;
  logic [7:0]            pixel_out;
  logic                  pixel_valid;
  logic                  sof;
  logic                  eol;

  modport master (
    input  start, pattern_sel, mem_rd_data,
    output busy, done, mem_rd_en, mem_addr,
    output pixel_out, pixel_valid, sof, eol
  );

  modport slave (
    output start, pattern_sel, mem_rd_data,
    input  busy, done, mem_rd_en, mem_addr,
    input  pixel_out, pixel_valid, sof, eol
  );
endinterface

// File: rtl/frame_reader.sv
// Raster-order frame-buffer reader with HBLANK gaps and sof/eol markers.
// Optional test pattern: define FRAME_READER_TEST_PATTERN_EN.
module frame_reader #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int HBLANK     = 16
) (
  input  logic          clk,
  input  logic          rst,
  frame_reader_if.master bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam int CW = $clog2(HBLANK + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_cnt;

  logic r_v1, r_sof1, r_eol1;
  logic r_v2, r_sof2, r_eol2;
  logic [7:0] r_pix;

  logic w_iss;
  logic w_last_x;
  logic w_last_y;
  logic [7:0] w_pix_d;

  assign w_iss    = (r_state == S_ACTIVE);
  assign w_last_x = (r_x == XW'(IMG_WIDTH - 1));
  assign w_last_y = (r_y == YW'(IMG_HEIGHT - 1));

`ifdef FRAME_READER_TEST_PATTERN_EN
  logic       r_pat;
  logic [7:0] r_pd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= 1'b0;
      r_pd1 <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start)
        r_pat <= bus.pattern_sel;
      r_pd1 <= 8'(r_x) + 8'(r_y);
    end
  end

  assign w_pix_d       = r_pat ? r_pd1 : bus.mem_rd_data;
  assign bus.mem_rd_en = w_iss & ~r_pat;
`else
  logic w_unused_pat;

  assign w_unused_pat  = bus.pattern_sel;
  assign w_pix_d       = bus.mem_rd_data;
  assign bus.mem_rd_en = w_iss;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.start) w_next = S_ACTIVE;
      S_ACTIVE:
        if (w_last_x) begin
          if (w_last_y)         w_next = S_DRAIN;
          else if (HBLANK == 0) w_next = S_ACTIVE;
          else                  w_next = S_HBLANK;
        end
      S_HBLANK:
        if (r_cnt == CW'(HBLANK - 1)) w_next = S_ACTIVE;
      S_DRAIN:
        if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  // Address keeps counting across lines, so y*W+x needs no multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (bus.start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
          end
        S_ACTIVE: begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
          r_cnt  <= '0;
          if (w_last_x) begin
            r_x <= '0;
            r_y <= r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        S_HBLANK, S_DRAIN:
          r_cnt <= r_cnt + CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_sof1 <= 1'b0;
      r_eol1 <= 1'b0;
      r_v2   <= 1'b0;
      r_sof2 <= 1'b0;
      r_eol2 <= 1'b0;
      r_pix  <= '0;
    end else begin
      r_v1   <= w_iss;
      r_sof1 <= w_iss && r_x == '0 && r_y == '0;
      r_eol1 <= w_iss && w_last_x;
      r_v2   <= r_v1;
      r_sof2 <= r_sof1;
      r_eol2 <= r_eol1;
      if (r_v1) r_pix <= w_pix_d;
    end
  end

  assign bus.mem_addr    = r_addr;
  assign bus.busy        = (r_state == S_ACTIVE) ||
                           (r_state == S_HBLANK) ||
                           (r_state == S_DRAIN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.pixel_out   = r_pix;
  assign bus.pixel_valid = r_v2;
  assign bus.sof         = r_sof2;
  assign bus.eol         = r_eol2;
endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: 4x3 frames, HBLANK=2 (dut0) and HBLANK=0 (dut1),
// random start/reset/pattern_sel against a schedule-based reference model.
module tb_frame_reader;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;
`ifdef FRAME_READER_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic start;
  logic pattern_sel;

  frame_reader_if #(.ADDR_WIDTH(AW)) bus0 ();
  frame_reader_if #(.ADDR_WIDTH(AW)) bus1 ();

  frame_reader #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .HBLANK(2)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  frame_reader #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .HBLANK(0)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  assign bus0.start       = start;
  assign bus1.start       = start;
  assign bus0.pattern_sel = pattern_sel;
  assign bus1.pattern_sel = pattern_sel;

  logic [7:0] ram [16];

  always @(posedge clk) begin
    if (bus0.mem_rd_en) bus0.mem_rd_data <= ram[bus0.mem_addr];
    if (bus1.mem_rd_en) bus1.mem_rd_data <= ram[bus1.mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle", nm, act, exp);
    end
  endtask

  // Reference model: a frame accepted at edge T reads pixel (l,p)
  // in cycle T + l*(W+HB) + p and shows it two cycles later.
  int cyc = 0;
  bit seen_rst = 0;
  int rst_cyc = -1;
  bit have [2];
  int T [2];
  bit pat [2];

  function automatic int hbv(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int done_of(input int d, input int t);
    return t + (H - 1) * (W + hbv(d)) + W - 1 + 3;
  endfunction

  function automatic bit is_rd(input int d, input int rel,
                               output int l, output int p);
    int per;
    per = W + hbv(d);
    l = 0;
    p = 0;
    if (rel < 0) return 1'b0;
    l = rel / per;
    p = rel % per;
    return (l < H) && (p < W);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      seen_rst = 1'b1;
      rst_cyc  = cyc;
      for (int d = 0; d < 2; d++) have[d] = 1'b0;
    end else if (start) begin
      for (int d = 0; d < 2; d++)
        if (!have[d] || cyc > done_of(d, T[d]) + 1) begin
          have[d] = 1'b1;
          T[d]    = cyc;
          pat[d]  = pattern_sel;
        end
    end
  end

  int nv [2], nsof [2], neol [2], ndone [2];
  int sof_c [2], last_v [2], done_c [2];
  logic [7:0] q0 [$];

  task automatic cmp(input int d, input logic busy, input logic done,
                     input logic rd, input logic [AW-1:0] addr,
                     input logic v, input logic [7:0] pix,
                     input logic sof, input logic eol);
    int l, p, l2, p2, rel, dn;
    bit rd_e, v_e, busy_e, done_e, sof_e, eol_e;
    logic [7:0] pe;
    rel    = cyc - T[d];
    dn     = done_of(d, T[d]);
    rd_e   = have[d] && is_rd(d, rel, l, p);
    v_e    = have[d] && is_rd(d, rel - 2, l2, p2);
    busy_e = have[d] && rel >= 0 && cyc < dn;
    done_e = have[d] && cyc == dn;
    sof_e  = v_e && l2 == 0 && p2 == 0;
    eol_e  = v_e && p2 == W - 1;
    chk($sformatf("ctl%0d c%0d", d, cyc), {busy, done, rd, v, sof, eol},
        {busy_e, done_e, rd_e && !(PAT_EN && pat[d]), v_e, sof_e, eol_e});
    if (rd_e)
      chk($sformatf("addr%0d c%0d", d, cyc), addr, l * W + p);
    if (v_e) begin
      if (PAT_EN && pat[d]) pe = 8'(l2 + p2);
      else                  pe = ram[l2 * W + p2];
      chk($sformatf("pix%0d c%0d", d, cyc), pix, pe);
    end
    if (cyc == rst_cyc)
      chk($sformatf("rstout%0d", d), {addr, pix}, 0);
    if (v === 1'b1) begin
      nv[d]++;
      last_v[d] = cyc;
      if (d == 0) q0.push_back(pix);
    end
    if (sof === 1'b1) begin
      nsof[d]++;
      sof_c[d] = cyc;
    end
    if (eol === 1'b1) neol[d]++;
    if (done === 1'b1) begin
      ndone[d]++;
      done_c[d] = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (seen_rst) begin
      cmp(0, bus0.busy, bus0.done, bus0.mem_rd_en, bus0.mem_addr,
          bus0.pixel_valid, bus0.pixel_out, bus0.sof, bus0.eol);
      cmp(1, bus1.busy, bus1.done, bus1.mem_rd_en, bus1.mem_addr,
          bus1.pixel_valid, bus1.pixel_out, bus1.sof, bus1.eol);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (bus0.done !== 1'b1 && k < 80) begin
      tick();
      k++;
    end
    chk("wait_done", bus0.done, 1);
  endtask

  int c0, dcyc;
  int s_nv [2], s_sof [2], s_eol [2], s_dn [2];

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      s_nv[d]  = nv[d];
      s_sof[d] = nsof[d];
      s_eol[d] = neol[d];
      s_dn[d]  = ndone[d];
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pattern_sel = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    repeat (10) tick();
    rst = 1'b0;
    tick();

    // Basic frame on both instances.
    snap();
    q0.delete();
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("acceptT", T[0], c0 + 1);
    wait_done();
    tick();
    chk("npix0", nv[0] - s_nv[0], 12);
    chk("npix1", nv[1] - s_nv[1], 12);
    chk("nsof0", nsof[0] - s_sof[0], 1);
    chk("neol0", neol[0] - s_eol[0], 3);
    chk("neol1", neol[1] - s_eol[1], 3);
    chk("ndone0", ndone[0] - s_dn[0], 1);
    chk("lat0", sof_c[0] - (c0 + 1), 2);
    chk("lat1", sof_c[1] - (c0 + 1), 2);
    chk("len0", done_c[0] - sof_c[0], 16);
    chk("len1", done_c[1] - sof_c[1], 12);
    chk("tail0", done_c[0] - last_v[0], 1);
    chk("tail1", done_c[1] - last_v[1], 1);
    chk("qlen", q0.size(), 12);
    for (int i = 0; i < 12 && i < q0.size(); i++)
      chk($sformatf("seq%0d", i), q0[i], i);

    // Start re-pulsed while active, then restart right after done.
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    dcyc = cyc;
    start = 1'b1;
    tick();
    chk("rep_npix", nv[0] - s_nv[0], 12);
    chk("rep_done", ndone[0] - s_dn[0], 1);
    tick();
    start = 1'b0;
    chk("restartT", T[0], dcyc + 2);
    snap();
    wait_done();
    tick();
    chk("f2_npix", nv[0] - s_nv[0], 12);
    chk("f2_done", ndone[0] - s_dn[0], 1);

    // Reset while dut0 shows pixel 5.
    repeat (3) tick();
    snap();
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < c0 + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_npix0", nv[0] - s_nv[0], 6);
    chk("rst_npix1", nv[1] - s_nv[1], 8);
    chk("rst_done0", ndone[0] - s_dn[0], 0);
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    tick();
    chk("post_npix", nv[0] - s_nv[0], 12);
    chk("post_sof", nsof[0] - s_sof[0], 1);

    // Random traffic with random RAM contents.
    repeat (4) tick();
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 500; i++) begin
      start       = ($urandom % 6) == 0;
      pattern_sel = 1'($urandom);
      rst         = ($urandom % 90) == 0;
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/frame_reader.md
# frame_reader

Raster-order pixel transmitter that reads an 8-bit grayscale frame from a synchronous frame-buffer RAM and streams it as `pixel_out`/`pixel_valid`, the input protocol of `convolution_engine`. It sits between the frame buffer and the filter pipeline. It inserts programmable horizontal blanking between lines so the engine's line buffers can settle. It also provides start-of-frame and end-of-line markers plus a one-cycle completion pulse.

## Interface
- `IMG_WIDTH`, 640, active pixels per line (≥2)
- `IMG_HEIGHT`, 480, lines per frame (≥1)
- `ADDR_WIDTH`, 19, frame-buffer address width; must satisfy 2^ADDR_WIDTH ≥ IMG_WIDTH*IMG_HEIGHT
- `HBLANK`, 16, idle cycles inserted between lines (0 allowed)

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one frame; sampled only in IDLE
- `pattern_sel`  in  1  1 = internal test pattern instead of RAM (see Configuration)
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last pixel
- `mem_rd_en`  out  1  RAM read strobe
- `mem_addr`  out  ADDR_WIDTH  RAM read address, y*IMG_WIDTH+x
- `mem_rd_data`  in  8  RAM data, valid the cycle after `mem_rd_en`
- `pixel_out`  out  8  streamed pixel
- `pixel_valid`  out  1  `pixel_out` valid this cycle
- `sof`  out  1  high with pixel (0,0) only
- `eol`  out  1  high with pixel x=IMG_WIDTH-1 of every line

## Operation
- States: IDLE, ACTIVE, HBLANK, DRAIN, DONE.
- IDLE: outputs low. `start`=1 → ACTIVE, with x=y=0 and addr=0. `start` in any other state is ignored.
- ACTIVE: `mem_rd_en`=1 every cycle; `mem_addr` = running address counter (+1 per cycle; no multiply). On x=IMG_WIDTH-1:
  - y<IMG_HEIGHT-1 → HBLANK, or straight to the next line's ACTIVE if HBLANK=0.
  - Last line → DRAIN.
- HBLANK: `mem_rd_en`=0 for exactly HBLANK cycles, then ACTIVE with y+1, x=0. The address counter continues without gap.
- DRAIN: waits for the 2-stage read pipeline to empty (2 cycles), then DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE. A new `start` is accepted the cycle after DONE.
- Sideband: `sof`/`eol` are generated from x/y at read issue and delayed through the same 2-stage pipeline as data, so they align with `pixel_valid`.
- Reset: `rst` at any time, including mid-frame, returns to IDLE on the next edge.
  - All outputs forced 0: `busy`, `done`, `mem_rd_en`, `mem_addr`, `pixel_out`, `pixel_valid`, `sof`, `eol`.
  - Pipeline flushed; no stale `pixel_valid` after reset.
- `pattern_sel` is sampled at `start` and held for the frame.

## Timing
- Read latency: `mem_rd_en` issued in cycle N; RAM data captured at end of N+1; `pixel_out`/`pixel_valid` asserted in cycle N+2. Fixed 2-cycle latency.
- Accepted `start` at edge T: first `mem_rd_en` in cycle T+1, first `pixel_valid` in T+3.
- Line period = IMG_WIDTH + HBLANK cycles; `pixel_valid` is contiguous within a line.
- Frame: IMG_WIDTH*IMG_HEIGHT valid cycles.
- `done` is asserted in the cycle immediately after the last `pixel_valid`; `busy` falls in that same cycle.
- No backpressure: the consumer must accept every valid pixel.

## Configuration
- Macro: `FRAME_READER_TEST_PATTERN_EN`.
- Defined: with `pattern_sel`=1 at `start`, `mem_rd_en` stays 0 for the whole frame. `pixel_out` = (x + y) mod 256 with identical timing, markers and latency. With `pattern_sel`=0, normal RAM reads.
- Undefined: pattern generator is not built. `pattern_sel` is ignored; RAM is always read.

## Test plan
Bench parameters: IMG_WIDTH=4, IMG_HEIGHT=3, HBLANK=2; RAM model holds addr mod 256.
- Reset 10 cycles, `start` pulse → `mem_addr` 0..11 in order; `pixel_out` 0..11 with exactly 12 `pixel_valid` cycles; `sof` only with pixel 0; `eol` with pixels 3, 7, 11; 2 idle cycles between lines; `done` the cycle after pixel 11.
- Latency check → first `pixel_valid` exactly 3 cycles after the `start` edge; each pixel 2 cycles after its `mem_rd_en`.
- HBLANK=0 → 12 contiguous valid cycles, `eol` at 3, 7, 11.
- `start` re-pulsed during ACTIVE → ignored; exactly 12 pixels, one `done`. `start` in the cycle after `done` → second identical frame.
- `rst` asserted at pixel 5 → the next cycle has all outputs 0, no further `pixel_valid`, state IDLE; a subsequent `start` gives a full clean frame from pixel 0.
- With `FRAME_READER_TEST_PATTERN_EN` and `pattern_sel`=1 → no `mem_rd_en`; line 0 = 0,1,2,3; line 1 = 1,2,3,4; line 2 = 2,3,4,5. Without the macro → RAM data regardless of `pattern_sel`.
